vga_pattern_gen: RTL and testbench
==================================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter N_COLS, default 2: colour-grid columns; H_ACTIVE SHALL be divisible by N_COLS.
REQ-004 Parameter N_ROWS, default 4: colour-grid rows; V_ACTIVE SHALL be divisible by N_ROWS.
REQ-005 Parameter CHK_LOG2, default 5: checkerboard square size is 2^CHK_LOG2 pixels.
REQ-006 Parameter BAR_W, default 32, and BAR_STEP, default 4: moving-bar width in pixels and advance per frame in pixels.
REQ-007 Port clk, input, 1: pixel clock; the only clock.
REQ-008 Port rstn, input, 1: reset, asynchronous assert, active-low.
REQ-009 Port hs_cnt, input, 12: current pixel column from the timing generator.
REQ-010 Port vs_cnt, input, 12: current line from the timing generator.
REQ-011 Port pattern_sel, input, 2: requested pattern (0 grid, 1 gray ramp, 2 checker, 3 moving bar).
REQ-012 Port pix_data, output, 24: RGB888 pixel value, {R,G,B}.
REQ-013 Port pix_valid, output, 1: high when pix_data belongs to the active area.

Function
REQ-014 Active area: hs_cnt < H_ACTIVE and vs_cnt < V_ACTIVE; outside it pix_data SHALL be 24'h000000 and pix_valid 0.
REQ-015 Latency: pix_data and pix_valid SHALL be registered, valid exactly 1 clk after the corresponding hs_cnt/vs_cnt sample.
REQ-016 Frame start: the cycle where hs_cnt==0 and vs_cnt==0.
REQ-017 The active mode SHALL be latched from pattern_sel only at frame start; pattern_sel changes mid-frame SHALL have no effect until the next frame.
REQ-018 Column index: a counter cleared at hs_cnt==0 that increments when hs_cnt reaches each multiple of H_ACTIVE/N_COLS; there SHALL be no divider.
REQ-019 Row index: a counter cleared at vs_cnt==0 that increments when vs_cnt reaches each multiple of V_ACTIVE/N_ROWS, updated once per line.
REQ-020 Mode 0 (grid): palette index = (row*N_COLS+col) mod 8. Palette: 0 000000, 1 0000FF, 2 FF0000, 3 FF00FF, 4 00FF00, 5 00FFFF, 6 FFFF00, 7 FFFFFF.
REQ-021 Mode 1 (ramp): gray level = floor(hs_cnt*256/H_ACTIVE), produced by an incremental error accumulator reset at hs_cnt==0; pix_data = {g,g,g}.
REQ-022 Mode 2 (checker): white when hs_cnt[CHK_LOG2] XOR vs_cnt[CHK_LOG2] = 1, else black.
REQ-023 Mode 3 (bar): white when bar_pos <= hs_cnt < bar_pos+BAR_W, else blue 0000FF; the bar SHALL NOT wrap across the right edge.
REQ-024 bar_pos SHALL advance by BAR_STEP at each frame start; when bar_pos+BAR_STEP >= H_ACTIVE it SHALL wrap to bar_pos+BAR_STEP-H_ACTIVE.
REQ-025 A 16-bit frame counter SHALL increment at each frame start and wrap 0xFFFF->0; it is internal and observable in simulation.
REQ-026 hs_cnt jumping back to 0 before H_ACTIVE SHALL clear the column and ramp state with no stale colour.

Reset
REQ-027 While rstn=0: pix_data=0, pix_valid=0, mode=0, bar_pos=0, frame counter=0, row/col indices=0, ramp accumulator=0.
REQ-028 Reset asserted mid-frame SHALL clear the outputs asynchronously; after release, output SHALL be black/invalid until the next valid active pixel, and mode SHALL stay 0 until the next frame start.

Structure
REQ-029 Package vga_pkg SHALL hold the 8-entry palette constants, pattern-mode encodings and the 12-bit counter width.
REQ-030 One sub-module, vga_frac_step (incremental floor(n*M/D) stepper), SHALL implement REQ-021.

Verification
REQ-031 Defaults, mode 0, (hs,vs)=(10,10) -> 1 clk later 000000; (330,130) -> FF00FF; (639,479) -> FFFFFF.
REQ-032 Mode 1, vs=5, hs=0/320/639 -> 000000 / 808080 / FFFFFF; hs=640 -> 000000 with pix_valid=0.
REQ-033 Mode 2, (32,0) -> FFFFFF; (32,32) -> 000000; (0,0) -> 000000.
REQ-034 Mode 3: after 3 frame starts, bar_pos=12; hs=12 -> FFFFFF, hs=44 -> 0000FF; with BAR_STEP=4 and bar_pos=636, the next frame gives bar_pos=0.
REQ-035 pattern_sel 0->2 at line 100 -> grid continues to frame end, checker from the next frame start; rstn pulse mid-line -> pix_data=0 immediately and frame counter=0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA test-pattern generator.
//   CNT_W          width of the hs/vs pixel/line counters
//   pattern_e      pattern-mode encodings carried on pattern_sel
//   COLOR_*        the eight palette colours (RGB888, {R,G,B})
//   palette_lookup maps a 3-bit palette index to its colour
//   frame_state_t  per-frame state (mode, bar position, frame counter)
package vga_pkg;

    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        PAT_GRID    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_BAR     = 2'd3
    } pattern_e;

    localparam logic [23:0] COLOR_BLACK   = 24'h000000;
    localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
    localparam logic [23:0] COLOR_RED     = 24'hFF0000;
    localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
    localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;

    function automatic logic [23:0] palette_lookup(input logic [2:0] idx);
        logic [23:0] rgb;
        rgb = COLOR_BLACK;
        case (idx)
            3'd0: rgb = COLOR_BLACK;
            3'd1: rgb = COLOR_BLUE;
            3'd2: rgb = COLOR_RED;
            3'd3: rgb = COLOR_MAGENTA;
            3'd4: rgb = COLOR_GREEN;
            3'd5: rgb = COLOR_CYAN;
            3'd6: rgb = COLOR_YELLOW;
            3'd7: rgb = COLOR_WHITE;
        endcase
        return rgb;
    endfunction

    // Everything that changes only at frame start lives here, so the whole
    // per-frame state is visible as one signal in simulation.
    typedef struct packed {
        pattern_e         mode;
        logic [CNT_W-1:0] bar_pos;
        logic [15:0]      frame_cnt;
    } frame_state_t;

endpackage

// File: rtl/vga_frac_step.sv
// vga_frac_step: incremental floor(n*M/D) stepper, no divider.
// n is implicit: i_clear sets n=0, each i_step cycle advances n by one.
//   clk      clock
//   rstn     asynchronous active-low reset
//   i_clear  current sample is n=0
//   i_step   current sample is previous n + 1
//   o_q      floor(n*M/D) for the current sample (combinational from state)
module vga_frac_step #(
    parameter int M   = 256,
    parameter int D   = 640,
    parameter int Q_W = 8,
    parameter int R_W = 12
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           i_clear,
    input  logic           i_step,
    output logic [Q_W-1:0] o_q
);

    localparam int RE_W = R_W + 1;
    // M/D and M%D are elaboration-time constants; hardware only adds/compares.
    localparam logic [Q_W-1:0]  C_Q_INC       = Q_W'(M / D);
    localparam logic [Q_W-1:0]  C_Q_INC_CARRY = Q_W'(M / D + 1);
    localparam logic [RE_W-1:0] C_R_INC       = RE_W'(M % D);
    localparam logic [RE_W-1:0] C_D           = RE_W'(D);

    logic [Q_W-1:0]  r_q;
    logic [R_W-1:0]  r_rem;
    logic [Q_W-1:0]  w_q;
    logic [R_W-1:0]  w_rem;
    logic [RE_W-1:0] w_rem_sum;

    // Invariant: q*D + rem == n*M with rem < D.
    always_comb begin
        w_rem_sum = {1'b0, r_rem} + C_R_INC;
        w_q       = r_q;
        w_rem     = r_rem;
        if (i_clear) begin
            w_q   = '0;
            w_rem = '0;
        end else if (i_step) begin
            if (w_rem_sum >= C_D) begin
                w_q   = r_q + C_Q_INC_CARRY;
                w_rem = R_W'(w_rem_sum - C_D);
            end else begin
                w_q   = r_q + C_Q_INC;
                w_rem = w_rem_sum[R_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q   <= '0;
            r_rem <= '0;
        end else begin
            r_q   <= w_q;
            r_rem <= w_rem;
        end
    end

    assign o_q = w_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern generator driven by an external timing
// generator's pixel/line counters.
//   clk          pixel clock
//   rstn         asynchronous active-low reset
//   hs_cnt       current pixel column
//   vs_cnt       current line
//   pattern_sel  requested pattern (0 grid, 1 ramp, 2 checker, 3 bar),
//                sampled only at frame start (hs_cnt==0 && vs_cnt==0)
//   pix_data     RGB888 {R,G,B}, one clock after the hs/vs sample
//   pix_valid    one clock after the sample, high when that sample was in
//                the active area; pix_data is black whenever it is low.
//                There is no back-pressure: every cycle carries a pixel.
// The column/row/ramp trackers assume hs_cnt advances by one per clock
// within a line; hs_cnt returning to 0 at any point restarts a line.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int N_COLS   = 2,
    parameter int N_ROWS   = 4,
    parameter int CHK_LOG2 = 5,
    parameter int BAR_W    = 32,
    parameter int BAR_STEP = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [CNT_W-1:0] hs_cnt,
    input  logic [CNT_W-1:0] vs_cnt,
    input  logic [1:0]       pattern_sel,
    output logic [23:0]      pix_data,
    output logic             pix_valid
);

    localparam int COL_W  = H_ACTIVE / N_COLS;
    localparam int ROW_H  = V_ACTIVE / N_ROWS;
    localparam int COL_IW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int ROW_IW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CE_W   = CNT_W + 1;

    localparam logic [CNT_W-1:0]  C_H_ACTIVE   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  C_V_ACTIVE   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  C_COL_W      = CNT_W'(COL_W);
    localparam logic [CNT_W-1:0]  C_ROW_H      = CNT_W'(ROW_H);
    localparam logic [COL_IW-1:0] C_COL_LAST   = COL_IW'(N_COLS - 1);
    localparam logic [ROW_IW-1:0] C_ROW_LAST   = ROW_IW'(N_ROWS - 1);
    localparam logic [CE_W-1:0]   C_H_ACTIVE_E = CE_W'(H_ACTIVE);
    localparam logic [CE_W-1:0]   C_BAR_W      = CE_W'(BAR_W);
    localparam logic [CE_W-1:0]   C_BAR_STEP   = CE_W'(BAR_STEP);
    localparam logic [2:0]        C_NCOLS3     = 3'(N_COLS);

    frame_state_t      r_st;
    frame_state_t      w_st;
    logic [COL_IW-1:0] r_col;
    logic [COL_IW-1:0] w_col;
    logic [CNT_W-1:0]  r_col_bound;
    logic [CNT_W-1:0]  w_col_bound;
    logic [ROW_IW-1:0] r_row;
    logic [ROW_IW-1:0] w_row;
    logic [CNT_W-1:0]  r_row_bound;
    logic [CNT_W-1:0]  w_row_bound;
    logic [23:0]       r_pix_data;
    logic              r_pix_valid;

    logic              w_active;
    logic              w_frame_start;
    logic [CE_W-1:0]   w_bar_sum;
    logic [CE_W-1:0]   w_bar_end;
    logic              w_in_bar;
    logic [2:0]        w_pal_idx;
    logic [7:0]        w_gray;
    logic [23:0]       w_rgb;

    assign w_active      = (hs_cnt < C_H_ACTIVE) && (vs_cnt < C_V_ACTIVE);
    assign w_frame_start = (hs_cnt == '0) && (vs_cnt == '0);

    // Per-frame state. The new values are used for the frame-start pixel
    // itself, so the first pixel of a frame already shows the new mode/bar.
    always_comb begin
        w_st      = r_st;
        w_bar_sum = {1'b0, r_st.bar_pos} + C_BAR_STEP;
        if (w_frame_start) begin
            w_st.mode      = pattern_e'(pattern_sel);
            w_st.frame_cnt = r_st.frame_cnt + 16'd1;
            if (w_bar_sum >= C_H_ACTIVE_E) begin
                w_st.bar_pos = CNT_W'(w_bar_sum - C_H_ACTIVE_E);
            end else begin
                w_st.bar_pos = w_bar_sum[CNT_W-1:0];
            end
        end
    end

    // Column tracker: r_col_bound holds the hs value where the next column
    // starts. Saturates at the last column so blanking cannot overflow it.
    always_comb begin
        w_col       = r_col;
        w_col_bound = r_col_bound;
        if (hs_cnt == '0) begin
            w_col       = '0;
            w_col_bound = C_COL_W;
        end else if ((hs_cnt == r_col_bound) && (r_col != C_COL_LAST)) begin
            w_col       = r_col + COL_IW'(1);
            w_col_bound = r_col_bound + C_COL_W;
        end
    end

    // Row tracker: evaluated only on the first pixel of each line.
    always_comb begin
        w_row       = r_row;
        w_row_bound = r_row_bound;
        if (hs_cnt == '0) begin
            if (vs_cnt == '0) begin
                w_row       = '0;
                w_row_bound = C_ROW_H;
            end else if ((vs_cnt == r_row_bound) && (r_row != C_ROW_LAST)) begin
                w_row       = r_row + ROW_IW'(1);
                w_row_bound = r_row_bound + C_ROW_H;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_st        <= '{mode: PAT_GRID, bar_pos: '0, frame_cnt: '0};
            r_col       <= '0;
            r_col_bound <= C_COL_W;
            r_row       <= '0;
            r_row_bound <= C_ROW_H;
        end else begin
            r_st        <= w_st;
            r_col       <= w_col;
            r_col_bound <= w_col_bound;
            r_row       <= w_row;
            r_row_bound <= w_row_bound;
        end
    end

    vga_frac_step #(
        .M   (256),
        .D   (H_ACTIVE),
        .Q_W (8),
        .R_W (CNT_W)
    ) u_ramp (
        .clk     (clk),
        .rstn    (rstn),
        .i_clear (hs_cnt == '0),
        .i_step  (1'b1),
        .o_q     (w_gray)
    );

    // Truncating each term to 3 bits keeps the product/sum correct mod 8.
    assign w_pal_idx = 3'(w_row) * C_NCOLS3 + 3'(w_col);

    // Bar compare is done one bit wider so it clips at the right edge
    // instead of wrapping.
    assign w_bar_end = {1'b0, w_st.bar_pos} + C_BAR_W;
    assign w_in_bar  = (hs_cnt >= w_st.bar_pos) && ({1'b0, hs_cnt} < w_bar_end);

    always_comb begin
        w_rgb = COLOR_BLACK;
        case (w_st.mode)
            PAT_GRID:    w_rgb = palette_lookup(w_pal_idx);
            PAT_RAMP:    w_rgb = {w_gray, w_gray, w_gray};
            PAT_CHECKER: w_rgb = (hs_cnt[CHK_LOG2] ^ vs_cnt[CHK_LOG2]) ? COLOR_WHITE : COLOR_BLACK;
            PAT_BAR:     w_rgb = w_in_bar ? COLOR_WHITE : COLOR_BLUE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pix_data  <= COLOR_BLACK;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= w_active;
            r_pix_data  <= w_active ? w_rgb : COLOR_BLACK;
        end
    end

    assign pix_data  = r_pix_data;
    assign pix_valid = r_pix_valid;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen at default parameters. Lines are
// driven as short sweeps (hs restarting at 0) so whole frames stay cheap;
// lines under test are swept from hs=0 up to the pixel being checked.
module tb_vga_pattern_gen;
    import vga_pkg::*;

    logic        clk;
    logic        rstn;
    logic [11:0] hs_cnt;
    logic [11:0] vs_cnt;
    logic [1:0]  pattern_sel;
    logic [23:0] pix_data;
    logic        pix_valid;

    int checks = 0;
    int errors = 0;

    vga_pattern_gen dut (
        .clk         (clk),
        .rstn        (rstn),
        .hs_cnt      (hs_cnt),
        .vs_cnt      (vs_cnt),
        .pattern_sel (pattern_sel),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int h, input int v);
        @(negedge clk);
        hs_cnt = 12'(h);
        vs_cnt = 12'(v);
    endtask

    // Two pixels per line: enough to step the row tracker each line.
    task automatic lines(input int v_first, input int v_last);
        for (int v = v_first; v <= v_last; v++) begin
            drive(0, v);
            drive(1, v);
        end
    endtask

    // Sweep hs 0..h_last on line v, then check the pixel for h_last.
    task automatic sweep_check(input string tag, input int v, input int h_last,
                               input logic [23:0] exp_data, input logic exp_valid);
        for (int h = 0; h <= h_last; h++) drive(h, v);
        @(posedge clk);
        #1;
        chk({tag, "_data"}, pix_data, exp_data);
        chk({tag, "_valid"}, pix_valid, exp_valid);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn        = 1'b0;
        hs_cnt      = '0;
        vs_cnt      = '0;
        pattern_sel = 2'd3;

        // Reset held across frame-start samples: nothing may move.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", pix_data, 24'h000000);
        chk("rst_valid", pix_valid, 1'b0);
        chk("rst_frame_cnt", dut.r_st.frame_cnt, 16'd0);
        chk("rst_bar_pos", dut.r_st.bar_pos, 12'd0);
        chk("rst_mode", dut.r_st.mode, 2'd0);
        @(negedge clk);
        rstn        = 1'b1;
        pattern_sel = 2'd0;

        // Grid frame.
        lines(0, 9);
        sweep_check("grid_10_10", 10, 10, 24'h000000, 1'b1);
        lines(11, 129);
        sweep_check("grid_330_130", 130, 330, 24'hFF00FF, 1'b1);
        // Line restart after reaching column 1 must fall back to column 0.
        sweep_check("grid_restart_5_130", 130, 5, 24'hFF0000, 1'b1);
        lines(131, 478);
        sweep_check("grid_639_479", 479, 639, 24'hFFFFFF, 1'b1);

        // Ramp frame.
        pattern_sel = 2'd1;
        lines(0, 4);
        sweep_check("ramp_0", 5, 0, 24'h000000, 1'b1);
        sweep_check("ramp_320", 5, 320, 24'h808080, 1'b1);
        sweep_check("ramp_639", 5, 639, 24'hFFFFFF, 1'b1);
        sweep_check("ramp_640", 5, 640, 24'h000000, 1'b0);

        // Checker frame.
        pattern_sel = 2'd2;
        sweep_check("chk_0_0", 0, 0, 24'h000000, 1'b1);
        sweep_check("chk_32_0", 0, 32, 24'hFFFFFF, 1'b1);
        lines(1, 31);
        sweep_check("chk_32_32", 32, 32, 24'h000000, 1'b1);

        // Mid-frame select change: grid holds until the next frame start.
        pattern_sel = 2'd0;
        lines(0, 99);
        pattern_sel = 2'd2;
        sweep_check("sw_grid_330_100", 100, 330, 24'h0000FF, 1'b1);
        lines(101, 129);
        sweep_check("sw_grid_330_130", 130, 330, 24'hFF00FF, 1'b1);
        lines(131, 479);
        sweep_check("sw_chk_32_0", 0, 32, 24'hFFFFFF, 1'b1);

        // Asynchronous reset pulse mid-line.
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_data", pix_data, 24'h000000);
        chk("arst_valid", pix_valid, 1'b0);
        chk("arst_frame_cnt", dut.r_st.frame_cnt, 16'd0);
        @(negedge clk);
        rstn   = 1'b1;
        hs_cnt = 12'd40;
        vs_cnt = 12'd0;
        @(posedge clk);
        #1;
        // Checker would be white at (40,0); grid row0/col0 is black.
        chk("post_rst_data", pix_data, 24'h000000);
        chk("post_rst_valid", pix_valid, 1'b1);
        chk("post_rst_mode", dut.r_st.mode, 2'd0);

        // Moving bar.
        pattern_sel = 2'd3;
        drive(0, 0);
        drive(1, 0);
        drive(0, 0);
        drive(1, 0);
        sweep_check("bar_12", 0, 12, 24'hFFFFFF, 1'b1);
        chk("bar_pos_3", dut.r_st.bar_pos, 12'd12);
        chk("frame_cnt_3", dut.r_st.frame_cnt, 16'd3);
        sweep_check("bar_43", 1, 43, 24'hFFFFFF, 1'b1);
        sweep_check("bar_44", 1, 44, 24'h0000FF, 1'b1);
        for (int i = 0; i < 156; i++) begin
            drive(0, 0);
            drive(1, 0);
        end
        chk("bar_pos_636", dut.r_st.bar_pos, 12'd636);
        sweep_check("bar636_hs0", 1, 0, 24'h0000FF, 1'b1);
        sweep_check("bar636_hs639", 1, 639, 24'hFFFFFF, 1'b1);
        drive(0, 0);
        drive(1, 0);
        chk("bar_pos_wrap", dut.r_st.bar_pos, 12'd0);
        chk("frame_cnt_160", dut.r_st.frame_cnt, 16'd160);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
